interrupt_sequencer: RTL

Interrupt controller for the multi-cycle MIPS processor. It watches the external INT and NMI lines and arbitrates between them, with NMI winning. The interrupt is taken only at an instruction boundary signalled by the control FSM. The block then sequences EPC save, vector dispatch and the INA acknowledge to the device, and stays in service until the handler executes eret.

---
 rtl/interrupt_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/interrupt_sequencer.sv
// ----------------------------------------------------------------------------
// interrupt_sequencer
//   Interrupt controller for the multi-cycle MIPS core. It arbitrates between
//   the level-sensitive maskable INT line and the edge-triggered NMI line, with
//   NMI winning. An interrupt is taken only at an instruction boundary. The
//   block then sequences the EPC save, the vector dispatch and the INA
//   acknowledge (INT only), and stays in service until the handler runs eret.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   INT            in   maskable request, level, active high
//   NMI            in   non-maskable request, rising-edge triggered
//   INTD           in   interrupt disable, masks INT only
//   instr_boundary in   1-cycle pulse at fetch-state entry
//   pc_current     in   PC of the next instruction to execute
//   eret           in   1-cycle handler-return pulse
//   take           out  1-cycle pulse: load handler_pc into PC
//   handler_pc     out  vector address, valid while take=1
//   epc_we         out  1-cycle EPC write enable
//   epc_out        out  value to write into EPC
//   cause          out  00 none, 01 INT, 10 NMI; held from SAVE until eret
//   INA            out  interrupt acknowledge to the device (INT only)
//   busy           out  high whenever the sequencer is not idle
// ----------------------------------------------------------------------------
module interrupt_sequencer #(
    parameter logic [31:0] VECTOR_NMI = 32'h8000_0100,
    parameter logic [31:0] VECTOR_INT = 32'h8000_0180,
    parameter int unsigned ACK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        NMI,
    input  logic        INTD,
    input  logic        instr_boundary,
    input  logic [31:0] pc_current,
    input  logic        eret,
    output logic        take,
    output logic [31:0] handler_pc,
    output logic        epc_we,
    output logic [31:0] epc_out,
    output logic [1:0]  cause,
    output logic        INA,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(ACK_CYCLES + 1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_INT  = 2'b01;
    localparam logic [1:0] CAUSE_NMI  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SAVE,
        S_DISPATCH,
        S_ACK,
        S_INSVC
    } state_t;

    state_t             state_q;
    logic               nmi_q;
    logic               nmi_pend_q;
    logic               nmi_pend_d;
    logic               int_req;
    logic               take_q;
    logic               epc_we_q;
    logic               ina_q;
    logic [1:0]         cause_q;
    logic [31:0]        hpc_q;
    logic [31:0]        epc_q;
    logic [CNT_W-1:0]   ack_cnt_q;

    // A new NMI edge in the same cycle as the SAVE-stage clear must win, so
    // the set is applied after the clear.
    always_comb begin
        int_req    = INT & ~INTD;
        nmi_pend_d = nmi_pend_q;
        if (state_q == S_SAVE && cause_q == CAUSE_NMI)
            nmi_pend_d = 1'b0;
        if (NMI && !nmi_q)
            nmi_pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            nmi_q      <= 1'b0;
            nmi_pend_q <= 1'b0;
            take_q     <= 1'b0;
            epc_we_q   <= 1'b0;
            ina_q      <= 1'b0;
            cause_q    <= CAUSE_NONE;
            hpc_q      <= 32'd0;
            epc_q      <= 32'd0;
            ack_cnt_q  <= '0;
        end else begin
            nmi_q      <= NMI;
            nmi_pend_q <= nmi_pend_d;
            take_q     <= 1'b0;
            epc_we_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (nmi_pend_q || int_req)
                        state_q <= S_ARM;
                end
                S_ARM: begin
                    // A request that vanished (dropped or masked) before the
                    // boundary is abandoned without side effects.
                    if (!(nmi_pend_q || int_req)) begin
                        state_q <= S_IDLE;
                    end else if (instr_boundary) begin
                        cause_q  <= nmi_pend_q ? CAUSE_NMI : CAUSE_INT;
                        epc_q    <= pc_current;
                        epc_we_q <= 1'b1;
                        state_q  <= S_SAVE;
                    end
                end
                S_SAVE: begin
                    hpc_q   <= (cause_q == CAUSE_NMI) ? VECTOR_NMI : VECTOR_INT;
                    take_q  <= 1'b1;
                    state_q <= S_DISPATCH;
                end
                S_DISPATCH: begin
                    if (cause_q == CAUSE_INT) begin
                        ina_q     <= 1'b1;
                        ack_cnt_q <= CNT_W'(ACK_CYCLES - 1);
                        state_q   <= S_ACK;
                    end else begin
                        state_q   <= S_INSVC;
                    end
                end
                S_ACK: begin
                    if (ack_cnt_q == '0) begin
                        ina_q   <= 1'b0;
                        state_q <= S_INSVC;
                    end else begin
                        ack_cnt_q <= ack_cnt_q - 1'b1;
                    end
                end
                S_INSVC: begin
                    if (eret) begin
                        cause_q <= CAUSE_NONE;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign take       = take_q;
    assign handler_pc = hpc_q;
    assign epc_we     = epc_we_q;
    assign epc_out    = epc_q;
    assign cause      = cause_q;
    assign INA        = ina_q;
    assign busy       = (state_q != S_IDLE);

endmodule
